// File: rtl/periph_burst_arbiter_pkg.sv
// Shared types and defaults for the peripheral RX burst arbiter.
package periph_burst_arbiter_pkg;

  localparam int unsigned num_peripherals  = 8;
  localparam int unsigned arb_num_channels = num_peripherals;
  localparam int unsigned arb_max_burst    = 4;

  typedef enum logic [0:0] {
    ArbIdle,
    ArbBurst
  } arb_state_t;

endpackage

// File: rtl/periph_burst_arbiter_rr_pick.sv
// Round-robin finder: first set bit of req at ptr+1 .. ptr+N (mod N). Combinational.
module rr_pick #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // Walk from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    int unsigned p;
    p     = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = N; i >= 1; i--) begin
      p = (32'(ptr) + i) % N;
      if (req[W'(p)]) begin
        found = 1'b1;
        idx   = W'(p);
      end
    end
  end

endmodule

// File: rtl/periph_burst_arbiter.sv
// Round-robin burst arbiter draining FWFT peripheral RX FIFOs into the outbound USB FIFO.
module periph_burst_arbiter
  import periph_burst_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = arb_num_channels,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned MAX_BURST    = arb_max_burst,
  parameter int unsigned GRANT_W      = $clog2(NUM_CHANNELS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CHANNELS-1:0][WIDTH-1:0]   rx_data,
  input  logic [NUM_CHANNELS-1:0]              rx_empty,
  input  logic [NUM_CHANNELS-1:0]              rx_almost_full,
  input  logic [NUM_CHANNELS-1:0]              chan_en,
  output logic [NUM_CHANNELS-1:0]              rx_read,
  output logic [WIDTH-1:0]                     out_data,
  output logic                                 out_valid,
  input  logic                                 out_full,
  output logic [GRANT_W-1:0]                   grant,
  output logic                                 busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  arb_state_t          state_q;
  logic [GRANT_W-1:0]  grant_q;
  logic [GRANT_W-1:0]  rr_ptr_q;
  logic [CntW-1:0]     burst_cnt_q;

  logic [NUM_CHANNELS-1:0] cand;
  logic [NUM_CHANNELS-1:0] urg;
  logic [NUM_CHANNELS-1:0] grant_oh;
  logic                    urg_found;
  logic                    cand_found;
  logic [GRANT_W-1:0]      urg_idx;
  logic [GRANT_W-1:0]      cand_idx;
  logic [GRANT_W-1:0]      pick;
  logic                    pop;
  logic                    leave;
  logic                    last_pop;

  assign cand     = ~rx_empty & chan_en;
  assign urg      = cand & rx_almost_full;
  assign grant_oh = NUM_CHANNELS'(1) << grant_q;

  rr_pick #(
    .N (NUM_CHANNELS),
    .W (GRANT_W)
  ) u_pick_urg (
    .req   (urg),
    .ptr   (rr_ptr_q),
    .found (urg_found),
    .idx   (urg_idx)
  );

  rr_pick #(
    .N (NUM_CHANNELS),
    .W (GRANT_W)
  ) u_pick_cand (
    .req   (cand),
    .ptr   (rr_ptr_q),
    .found (cand_found),
    .idx   (cand_idx)
  );

  assign pick = urg_found ? urg_idx : cand_idx;

  // Burst rules in priority order: end, preempt, stall, pop.
  always_comb begin
    pop   = 1'b0;
    leave = 1'b0;
    if (state_q == ArbBurst) begin
      if (rx_empty[grant_q] || !chan_en[grant_q]) begin
        leave = 1'b1;
      end else if (((urg & ~grant_oh) != '0) && !rx_almost_full[grant_q]) begin
        leave = 1'b1;
      end else if (!out_full) begin
        pop = 1'b1;
      end
    end
  end

  assign last_pop = pop && (burst_cnt_q == CntW'(MAX_BURST - 1));

  // Pop and write share one cycle so no word is ever half-transferred.
  assign rx_read   = pop ? grant_oh : '0;
  assign out_valid = pop;
  assign out_data  = pop ? rx_data[grant_q] : '0;
  assign grant     = grant_q;
  assign busy      = (state_q == ArbBurst);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ArbIdle;
      grant_q     <= '0;
      rr_ptr_q    <= GRANT_W'(NUM_CHANNELS - 1);
      burst_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ArbIdle: begin
          if (cand_found) begin
            grant_q     <= pick;
            rr_ptr_q    <= pick;
            burst_cnt_q <= '0;
            state_q     <= ArbBurst;
          end
        end
        ArbBurst: begin
          if (leave) begin
            state_q <= ArbIdle;
          end else if (pop) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
            if (last_pop) begin
              state_q <= ArbIdle;
            end
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

endmodule
